// File: rtl/sw_debounce.sv
// Three-channel switch debouncer: each raw switch is synchronized, then accepted as the
// new stable level only after DEB_N consecutive clock edges that disagree with it.

module sw_debounce_lane #(
    parameter int DEB_N = 1000000,
    parameter int CNT_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_N - 1);

    logic             sync1_q, sync2_q;
    logic             st_q, st_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
        end
    end

    // The state is implied by comparing the synchronized level with the stable bit.
    always_comb begin
        state  = (sync2_q != st_q) ? COUNT : IDLE;
        cnt_d  = '0;
        st_d   = st_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        case (state)
            IDLE: cnt_d = '0;
            COUNT: begin
                // >= keeps the counter bounded even if it were ever corrupted past the limit
                if (cnt_q >= CNT_LAST) begin
                    st_d   = sync2_q;
                    rise_d = sync2_q;
                    fall_d = ~sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            st_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign stable_o = st_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

module sw_debounce #(
    parameter int DEB_N = 1000000,
    parameter int CNT_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] SW,
    output logic [2:0] sw_stable,
    output logic [2:0] sw_rise,
    output logic [2:0] sw_fall
);

    localparam int NUM_CH = 3;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sw_debounce_lane #(
            .DEB_N(DEB_N),
            .CNT_W(CNT_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .sw_i    (SW[i]),
            .stable_o(sw_stable[i]),
            .rise_o  (sw_rise[i]),
            .fall_o  (sw_fall[i])
        );
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter DEB_N, default 1000000, number of consecutive clock edges a synchronized switch level must differ from the stable level before it is accepted; legal range 2 to 2^CNT_W-1.
REQ-002 Parameter CNT_W, default 20, width of each per-channel debounce counter.
REQ-003 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port SW  input  3  raw board switch levels, asynchronous to clk, may bounce.
REQ-006 Port sw_stable  output  3  debounced switch levels, registered, fed to the downstream top-level SW input.
REQ-007 Port sw_rise  output  3  one-cycle pulse per channel when sw_stable goes 0->1.
REQ-008 Port sw_fall  output  3  one-cycle pulse per channel when sw_stable goes 1->0.

Function
REQ-009 Each of the 3 channels SHALL be independent and identical; no cross-channel interaction.
REQ-010 Each channel SHALL pass SW[i] through a two-flop synchronizer (sync1, sync2); only sync2, called s, SHALL be used by the debounce logic.
REQ-011 Each channel SHALL hold a CNT_W-bit counter cnt and a stable bit st, driving sw_stable[i].
REQ-012 Channel state machine SHALL have two states: IDLE (s == st) and COUNT (s != st); the state is implied by cnt and the comparison, and no separate state register is required.
REQ-013 On an edge with s == st: cnt SHALL clear to 0, st SHALL hold, and the pulses SHALL be 0.
REQ-014 On an edge with s != st and cnt < DEB_N-1: cnt SHALL increment by 1, st SHALL hold, and the pulses SHALL be 0.
REQ-015 On an edge with s != st and cnt == DEB_N-1: st SHALL load s, cnt SHALL clear to 0, and sw_rise[i] (if s=1) or sw_fall[i] (if s=0) SHALL assert for exactly that one following cycle.
REQ-016 Latency: for a clean level change first sampled by sync1 on edge 1, sw_stable SHALL update on edge DEB_N+2, and the matching pulse SHALL be high from edge DEB_N+2 to edge DEB_N+3.
REQ-017 Glitch rejection: any return of s to st before the accept edge SHALL clear cnt to 0, so acceptance requires DEB_N consecutive differing edges.
REQ-018 cnt SHALL never exceed DEB_N-1 and SHALL never wrap.
REQ-019 sw_rise[i] and sw_fall[i] SHALL never be high in the same cycle; a pulse SHALL never be high for two consecutive cycles.
REQ-020 Simultaneous changes on several channels SHALL be debounced in parallel, and pulses may coincide across channels.
REQ-021 All outputs SHALL be driven directly from flops, with no combinational path from SW to any output.

Reset
REQ-022 While rst=0: sync1, sync2, st, cnt, sw_rise and sw_fall SHALL be 0 immediately, without waiting for a clock edge.
REQ-023 Reset asserted mid-count SHALL discard the partial count; after release, counting SHALL restart from 0.
REQ-024 On the first edges after rst deasserts, a switch already held high SHALL be treated as a normal 0->1 change, producing one sw_rise pulse after the REQ-016 latency.

Verification (DEB_N=4, clk period 20 ns)
REQ-025 Reset with rst=0 held for 20 ns and SW=3'b000 -> sw_stable=000, sw_rise=000 and sw_fall=000 during reset and afterwards.
REQ-026 SW[0] changes 0->1 cleanly before edge 1 -> sw_stable[0]=1 after edge 6, sw_rise[0]=1 only for the cycle between edges 6 and 7, and sw_fall=000 throughout.
REQ-027 SW[1] bounces as 1 for 2 cycles, then 0 for 1 cycle, then 1 steadily -> exactly one sw_rise[1] pulse, occurring DEB_N+2 edges after the start of the steady 1, with no earlier change of sw_stable[1].
REQ-028 SW[2] pulse of 3 cycles (shorter than DEB_N) -> sw_stable[2] stays 0, with no pulses.
REQ-029 SW=111 then later SW=000, each held for 10 cycles -> all three sw_rise bits pulse in the same cycle, and later all three sw_fall bits pulse in the same cycle.
REQ-030 rst asserted 2 edges into a count on SW[0]=1, then released with SW[0] still 1 -> outputs are 0 during reset, and sw_rise[0] pulses DEB_N+2 edges after release.
